// File: rtl/teclado_pkg.sv
// Shared types and helpers for the 4x4 keypad emulator: FSM states, key decode
// and the LFSR feedback definition.
package teclado_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS_B,
        ST_HOLD,
        ST_REL_B,
        ST_DONE
    } state_e;

    localparam int unsigned LFSR_W = 16;

    // Right-shifting Fibonacci form: feedback bits 0,2,3,5 realise taps 16,14,13,11.
    localparam logic [LFSR_W-1:0] LFSR_TAPS         = 16'h002D;
    localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

    function automatic logic [1:0] key_row(input logic [3:0] key);
        return key[3:2];
    endfunction

    function automatic logic [1:0] key_col(input logic [3:0] key);
        return key[1:0];
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used as the bounce-interval source.
module lfsr16
    import teclado_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] state_o
);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {^(lfsr_q & LFSR_TAPS), lfsr_q[LFSR_W-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= SEED;
        else     lfsr_q <= lfsr_d;
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/teclado_emulador.sv
// Single-key 4x4 keypad emulator: answers the scanner's column drive with row levels,
// adding LFSR-timed contact bounce around each commanded press.
module teclado_emulador
    import teclado_pkg::*;
#(
    parameter int unsigned       BOUNCE_EDGES = 6,
    parameter int unsigned       BOUNCE_W     = 8,
    parameter int unsigned       HOLD_W       = 24,
    parameter logic [LFSR_W-1:0] LFSR_SEED    = LFSR_DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_key,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic [3:0]        columnas,
    output logic [3:0]        filas,
    output logic              contacto,
    output logic              busy,
    output logic              done
);

    localparam int unsigned EDGE_W = (BOUNCE_EDGES > 0) ? $clog2(BOUNCE_EDGES + 1) : 1;
    localparam logic [LFSR_W-1:0] LOAD_MASK = LFSR_W'((32'd1 << BOUNCE_W) - 32'd1);

    if (BOUNCE_EDGES % 2 != 0) begin : g_bad_edges
        $error("teclado_emulador: BOUNCE_EDGES must be even");
    end
    if (BOUNCE_W < 1 || BOUNCE_W > LFSR_W) begin : g_bad_width
        $error("teclado_emulador: BOUNCE_W must be 1..16");
    end
    if (LFSR_SEED == '0) begin : g_bad_seed
        $error("teclado_emulador: LFSR_SEED must be nonzero");
    end

    state_e              state_q, state_d;
    logic [3:0]          key_q, key_d;
    logic [HOLD_W-1:0]   cnt_q, cnt_d;
    logic [BOUNCE_W-1:0] timer_q, timer_d;
    logic [EDGE_W-1:0]   edge_q, edge_d;
    logic                contacto_q, contacto_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [LFSR_W-1:0]   lfsr_s;
    logic [BOUNCE_W-1:0] bounce_load;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .state_o (lfsr_s)
    );

    assign bounce_load = BOUNCE_W'(lfsr_s & LOAD_MASK);

    // cnt_q carries the latched hold time until HOLD, then counts it down.
    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        cnt_d      = cnt_q;
        timer_d    = timer_q;
        edge_d     = edge_q;
        contacto_d = contacto_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    key_d      = cmd_key;
                    cnt_d      = (cmd_hold == '0) ? HOLD_W'(1) : cmd_hold;
                    contacto_d = 1'b1;
                    timer_d    = bounce_load;
                    edge_d     = '0;
                    state_d    = (BOUNCE_EDGES == 0) ? ST_HOLD : ST_PRESS_B;
                end
            end
            ST_PRESS_B, ST_REL_B: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - BOUNCE_W'(1);
                end else if (edge_q < EDGE_W'(BOUNCE_EDGES)) begin
                    contacto_d = !contacto_q;
                    edge_d     = edge_q + EDGE_W'(1);
                    timer_d    = bounce_load;
                end else begin
                    state_d = (state_q == ST_PRESS_B) ? ST_HOLD : ST_DONE;
                end
            end
            ST_HOLD: begin
                if (cnt_q <= HOLD_W'(1)) begin
                    contacto_d = 1'b0;
                    edge_d     = '0;
                    timer_d    = bounce_load;
                    state_d    = (BOUNCE_EDGES == 0) ? ST_DONE : ST_REL_B;
                end else begin
                    cnt_d = cnt_q - HOLD_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            key_q      <= '0;
            cnt_q      <= '0;
            timer_q    <= '0;
            edge_q     <= '0;
            contacto_q <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            edge_q     <= edge_d;
            contacto_q <= contacto_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Row return follows the column drive with no latency; only the emulated key's row.
    always_comb begin
        filas = 4'hF;
        if (contacto_q && !columnas[key_col(key_q)]) begin
            filas[key_row(key_q)] = 1'b0;
        end
    end

    assign cmd_ready = ready_q;
    assign contacto  = contacto_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_teclado_emulador.sv
// Bench for teclado_emulador: one instance without bounce, one with 4 bounce edges,
// both checked every cycle against a segment-timeline model plus directed literal checks.
module tb_teclado_emulador;

    localparam int unsigned HW    = 24;
    localparam int unsigned SEQ_N = 40000;
    localparam int unsigned TL_N  = 512;

    typedef struct packed {
        logic closed;
        logic busy;
        logic done;
        logic ready;
    } exp_t;

    localparam exp_t IDLE_EXP = '{closed: 1'b0, busy: 1'b0, done: 1'b0, ready: 1'b1};

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    valid;
    logic [3:0]    key;
    logic [HW-1:0] hold;
    logic [3:0]    columnas;
    logic          rand_cols;
    logic [1:0]    ready_o, busy_o, done_o, contacto_o;
    logic [3:0]    filas_o [2];

    int            checks   = 0;
    int            failures = 0;

    logic [15:0]   seq [SEQ_N];
    int            be    [2] = '{0, 4};
    logic [15:0]   bmask [2] = '{16'h00FF, 16'h000F};
    exp_t          tl [2][TL_N];
    int            head [2] = '{0, 0};
    int            tail [2] = '{0, 0};
    logic [1:0]    acc = 2'b00;
    int            t_acc [2] = '{0, 0};
    logic [3:0]    mkey [2] = '{4'h0, 4'h0};
    int            cyc  = 0;
    int            tick = 0;

    always #5 clk = ~clk;

    teclado_emulador #(.BOUNCE_EDGES(0), .BOUNCE_W(8), .HOLD_W(HW)) dut0 (
        .clk(clk), .rst(rst), .cmd_valid(valid[0]), .cmd_ready(ready_o[0]),
        .cmd_key(key), .cmd_hold(hold), .columnas(columnas), .filas(filas_o[0]),
        .contacto(contacto_o[0]), .busy(busy_o[0]), .done(done_o[0])
    );

    teclado_emulador #(.BOUNCE_EDGES(4), .BOUNCE_W(4), .HOLD_W(HW)) dut4 (
        .clk(clk), .rst(rst), .cmd_valid(valid[1]), .cmd_ready(ready_o[1]),
        .cmd_key(key), .cmd_hold(hold), .columnas(columnas), .filas(filas_o[1]),
        .contacto(contacto_o[1]), .busy(busy_o[1]), .done(done_o[1])
    );

    task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t got=%0h exp=%0h", name, k, $time, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_filas(input logic [3:0] k, input logic cl, input logic [3:0] cols);
        logic [3:0] f;
        f = 4'hF;
        if (cl && cols[k[1:0]] == 1'b0) f[k[3:2]] = 1'b0;
        return f;
    endfunction

    task automatic push(input int k, input logic cl, input logic dn);
        tl[k][tail[k]] = '{closed: cl, busy: 1'b1, done: dn, ready: 1'b0};
        tail[k] = tail[k] + 1;
    endtask

    // Expected per-cycle outputs from the cycle after acceptance up to the done pulse.
    task automatic build(input int k);
        int c, v, hh;
        head[k] = 0;
        tail[k] = 0;
        c  = cyc;
        hh = (hold == '0) ? 1 : int'(hold);
        if (be[k] > 0) begin
            for (int seg = 0; seg <= be[k]; seg++) begin
                v = int'(seq[c] & bmask[k]) + 1;
                for (int j = 0; j < v; j++) push(k, (seg % 2) == 0, 1'b0);
                c = c + v;
            end
        end
        for (int j = 0; j < hh; j++) push(k, 1'b1, 1'b0);
        c = c + hh;
        if (be[k] > 0) begin
            for (int seg = 0; seg <= be[k]; seg++) begin
                v = int'(seq[c] & bmask[k]) + 1;
                for (int j = 0; j < v; j++) push(k, (seg % 2) == 1, 1'b0);
                c = c + v;
            end
        end
        push(k, 1'b0, 1'b1);
    endtask

    always @(posedge clk) begin
        if (rst) begin
            cyc = 0;
            for (int k = 0; k < 2; k++) begin
                head[k] = 0;
                tail[k] = 0;
                acc[k]  = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                acc[k] = 1'b0;
                if (head[k] < tail[k]) begin
                    head[k] = head[k] + 1;
                end else if (valid[k]) begin
                    build(k);
                    acc[k]   = 1'b1;
                    t_acc[k] = tick;
                    mkey[k]  = key;
                end
            end
            cyc = cyc + 1;
        end
        tick = tick + 1;
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            e = (rst || head[k] >= tail[k]) ? IDLE_EXP : tl[k][head[k]];
            chk("contacto", k, 32'(contacto_o[k]), 32'(e.closed));
            chk("busy", k, 32'(busy_o[k]), 32'(e.busy));
            chk("done", k, 32'(done_o[k]), 32'(e.done));
            chk("cmd_ready", k, 32'(ready_o[k]), 32'(e.ready));
            chk("filas", k, 32'(filas_o[k]), 32'(exp_filas(mkey[k], e.closed, columnas)));
        end
    end

    always @(posedge clk) begin
        if (rand_cols) begin
            #2 columnas = 4'($urandom);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [1:0] mask, input logic [3:0] k, input logic [HW-1:0] h);
        int budget;
        budget = 0;
        key    = k;
        hold   = h;
        valid  = mask;
        while (valid != 2'b00 && budget < 5000) begin
            @(posedge clk);
            #2;
            valid = valid & ~acc;
            budget++;
        end
        if (valid != 2'b00) begin
            chk("accept_timeout", 0, 32'(valid), 32'd0);
            valid = 2'b00;
        end
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        while ((head[0] < tail[0] || head[1] < tail[1]) && b < 5000) begin
            @(posedge clk);
            b++;
        end
        if (b >= 5000) chk("idle_timeout", 0, 32'(b), 32'd0);
        step(2);
    endtask

    initial begin
        logic [15:0] s;
        int cnt, cnt2, off, first_off, done_off, trans, run, maxrun, t1;
        logic prev;

        rst = 1'b1; valid = 2'b00; key = 4'h0; hold = '0; columnas = 4'hF; rand_cols = 1'b0;
        s = 16'hACE1;
        for (int i = 0; i < int'(SEQ_N); i++) begin
            seq[i] = s;
            s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
        end
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // reset state
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_filas", k, 32'(filas_o[k]), 32'hF);
            chk("rst_ready", k, 32'(ready_o[k]), 32'd1);
            chk("rst_busy", k, 32'(busy_o[k]), 32'd0);
        end
        step(1);

        // no-bounce press on key 6
        columnas = 4'b1011;
        send(2'b01, 4'h6, 24'd10);
        cnt = 0; first_off = -1; done_off = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            off = tick - t_acc[0];
            if (filas_o[0] == 4'b1101) begin
                cnt++;
                if (first_off < 0) first_off = off;
            end
            if (done_o[0]) done_off = off;
        end
        chk("nb_low_cycles", 0, 32'(cnt), 32'd10);
        chk("nb_first_low", 0, 32'(first_off), 32'd1);
        chk("nb_done_at", 0, 32'(done_off), 32'd11);
        wait_idle();

        // wrong column
        columnas = 4'b1110;
        send(2'b01, 4'h6, 24'd10);
        cnt = 0; cnt2 = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (filas_o[0] != 4'hF) cnt++;
            if (contacto_o[0]) cnt2++;
        end
        chk("wc_rows_low", 0, 32'(cnt), 32'd0);
        chk("wc_closed_cycles", 0, 32'(cnt2), 32'd10);
        wait_idle();

        // bounce count
        columnas = 4'b1011;
        prev = contacto_o[1];
        send(2'b10, 4'h6, 24'd100);
        trans = 0; run = 0; maxrun = 0; done_off = -1;
        for (int i = 0; i < 2000 && done_off < 0; i++) begin
            @(negedge clk);
            if (contacto_o[1] != prev) trans++;
            prev = contacto_o[1];
            run = prev ? run + 1 : 0;
            if (run > maxrun) maxrun = run;
            if (done_o[1]) done_off = i;
        end
        chk("bb_done_seen", 1, 32'(done_off >= 0), 32'd1);
        chk("bb_transitions", 1, 32'(trans), 32'd10);
        chk("bb_hold_closed", 1, 32'(maxrun >= 100), 32'd1);
        chk("bb_end_open", 1, 32'(prev), 32'd0);
        @(negedge clk);
        chk("bb_busy_after", 1, 32'(busy_o[1]), 32'd0);
        chk("bb_ready_after", 1, 32'(ready_o[1]), 32'd1);
        wait_idle();

        // back-pressure: second command waits for the first to finish
        columnas = 4'b0111;
        send(2'b01, 4'h6, 24'd20);
        t1 = t_acc[0];
        send(2'b01, 4'h3, 24'd5);
        chk("bp_accept_gap", 0, 32'(t_acc[0] - t1), 32'd22);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (filas_o[0] == 4'b1110) cnt++;
        end
        chk("bp_row0_cycles", 0, 32'(cnt), 32'd5);
        wait_idle();

        // asynchronous reset in HOLD
        columnas = 4'b1011;
        send(2'b01, 4'h6, 24'd30);
        step(5);
        chk("ar_pre_filas", 0, 32'(filas_o[0]), 32'b1101);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("ar_filas", 0, 32'(filas_o[0]), 32'hF);
        chk("ar_contacto", 0, 32'(contacto_o[0]), 32'd0);
        chk("ar_busy", 0, 32'(busy_o[0]), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("ar_ready", 0, 32'(ready_o[0]), 32'd1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_o[0]) cnt++;
        end
        chk("ar_no_done", 0, 32'(cnt), 32'd0);
        step(1);

        // corner key F with all columns driven
        columnas = 4'b0000;
        send(2'b01, 4'hF, 24'd8);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (filas_o[0] == 4'b0111) cnt++;
        end
        chk("ck_row3_cycles", 0, 32'(cnt), 32'd8);
        wait_idle();

        // randomized commands with a wandering column drive
        rand_cols = 1'b1;
        for (int n = 0; n < 25; n++) begin
            send(2'($urandom_range(1, 3)), 4'($urandom), HW'($urandom_range(0, 30)));
            step(int'($urandom_range(1, 4)));
        end
        wait_idle();
        rand_cols = 1'b0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "bench timeout");
    end

endmodule
